syscall_read_string: RTL

- Hardware engine for the read-string syscall (service 8). It is the input-direction counterpart of the print-string character path.
- It consumes a toggle-strobed character stream from the host/console side and writes the bytes into data memory starting at byte address a0, storing at most a1-1 characters.
- It then NUL-terminates the string and pulses done so the pipeline can release its syscall stall.
- Sits beside data_memory and drives a byte-lane write port into it.

---
 rtl/syscall_pkg.sv | 35 +++
 rtl/syscall_read_string_toggle_rx.sv | 41 ++++
 rtl/syscall_read_string.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/syscall_pkg.sv
// -----------------------------------------------------------------------------
// syscall_pkg
// Shared definitions for the read-string syscall engine (service 8):
//   - rs_state_t       : engine state encoding
//   - constants        : service number, newline byte, writable data window
//   - char-bus layout  : 9-bit toggle-strobed character bus, TOG_BIT = 8
//   - lane_enable()    : one-hot byte-lane enable from a byte address
// No ports (package).
// -----------------------------------------------------------------------------
package syscall_pkg;

    localparam int unsigned SYSCALL_READ_STRING = 8;

    localparam logic [7:0]  NEWLINE_CHAR       = 8'h0A;
    localparam logic [31:0] DATA_BEGIN_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] DATA_END_DEFAULT   = 32'h0041_0F00;

    // Character bus: bit 8 flips once per new character, [7:0] carries it.
    localparam int TOG_BIT  = 8;
    localparam int CHAR_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        WCHR,
        WNUL,
        FIN
    } rs_state_t;

    // Byte lane k covers bits [8k+7:8k]; lane index = low two address bits.
    function automatic logic [3:0] lane_enable(input logic [1:0] byte_off);
        return 4'b0001 << byte_off;
    endfunction

endpackage

// File: rtl/syscall_read_string_toggle_rx.sv
// -----------------------------------------------------------------------------
// toggle_rx
// Receiver for a toggle-strobed character bus. A character is pending while
// the bus toggle bit differs from the locally held copy (last_tog).
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset; last_tog loads the bus bit
//   char_in  in   [8] toggle strobe, [7:0] character
//   resync   in   load last_tog from the bus (discards any stale toggle)
//   accept   in   consume the pending character this cycle (if valid)
//   valid    out  a new character is pending (combinational)
//   data     out  the pending character byte (combinational)
// -----------------------------------------------------------------------------
module toggle_rx
    import syscall_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [CHAR_W:0]    char_in,
    input  logic               resync,
    input  logic               accept,
    output logic               valid,
    output logic [CHAR_W-1:0]  data
);

    logic last_tog;

    assign valid = char_in[TOG_BIT] ^ last_tog;
    assign data  = char_in[CHAR_W-1:0];

    // NOTE: registers are assigned with <= so every flop samples the
    // pre-edge values, regardless of statement order across blocks.
    always_ff @(posedge clk) begin
        if (reset || resync) begin
            last_tog <= char_in[TOG_BIT];
        end else if (accept && valid) begin
            last_tog <= char_in[TOG_BIT];
        end
    end

endmodule

// File: rtl/syscall_read_string.sv
// -----------------------------------------------------------------------------
// syscall_read_string
// Read-string syscall engine: receives a toggle-strobed character stream and
// writes it byte-by-byte into data memory at a0, storing at most a1-1
// characters, then a NUL terminator, then pulses done.
// Optional feature macro: READ_STRING_ECHO_EN (adds char_echo output that
// re-emits each stored character in print-path toggle format).
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   start                 syscall request, acted on at its rising edge
//   a0, a1                buffer address / signed length, sampled at start
//   char_in[8:0]          [8] toggle strobe, [7:0] character
//   mem_we/addr/wdata/be  single-lane byte write port to data memory
//   busy, done            request in flight / one-cycle completion pulse
//   count                 characters stored (NUL excluded), held until start
//   err                   a write fell outside [DATA_BEGIN, DATA_END]
//   char_echo[8:0]        (READ_STRING_ECHO_EN only) echo of stored chars
// -----------------------------------------------------------------------------
module syscall_read_string
    import syscall_pkg::*;
#(
    parameter logic [31:0] DATA_BEGIN = DATA_BEGIN_DEFAULT,
    parameter logic [31:0] DATA_END   = DATA_END_DEFAULT,
    parameter logic [7:0]  NEWLINE    = NEWLINE_CHAR
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [8:0]  char_in,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        busy,
    output logic        done,
    output logic [31:0] count,
    output logic        err
`ifdef READ_STRING_ECHO_EN
    ,
    output logic [8:0]  char_echo
`endif
);

    rs_state_t   state, state_n;
    logic        start_q;
    logic        start_edge;
    logic [31:0] ptr;
    logic [31:0] lim;
    logic [7:0]  char_q;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        addr_ok;

    assign start_edge = start & ~start_q;
    assign addr_ok    = (ptr >= DATA_BEGIN) && (ptr <= DATA_END);

    toggle_rx u_rx (
        .clk     (clk),
        .reset   (reset),
        .char_in (char_in),
        .resync  ((state == IDLE) && start_edge),
        .accept  (state == WAIT),
        .valid   (rx_valid),
        .data    (rx_data)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_n   = state;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    if ($signed(a1) <= 0) state_n = FIN;
                    else if (a1 == 32'd1) state_n = WNUL;
                    else                  state_n = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (rx_valid) state_n = (rx_data == 8'h00) ? WNUL : WCHR;
            end
            WCHR: begin
                busy      = 1'b1;
                mem_we    = addr_ok;
                mem_addr  = ptr;
                mem_be    = lane_enable(ptr[1:0]);
                mem_wdata = {4{char_q}};
                // count+1 is the post-write count; lim-1 leaves room for NUL.
                if (char_q == NEWLINE || (count + 32'd1) == (lim - 32'd1))
                    state_n = WNUL;
                else
                    state_n = WAIT;
            end
            WNUL: begin
                busy     = 1'b1;
                mem_we   = addr_ok;
                mem_addr = ptr;
                mem_be   = lane_enable(ptr[1:0]);
                state_n  = FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q <= 1'b0;
            ptr     <= '0;
            lim     <= '0;
            char_q  <= '0;
            count   <= '0;
            err     <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        ptr   <= a0;
                        lim   <= a1;
                        count <= '0;
                        err   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (rx_valid) char_q <= rx_data;
                end
                WCHR: begin
                    // Out-of-window writes are dropped but still consume a
                    // slot, so ptr and count advance exactly as in range.
                    ptr   <= ptr + 32'd1;
                    count <= count + 32'd1;
                    if (!addr_ok) err <= 1'b1;
                end
                WNUL: begin
                    if (!addr_ok) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef READ_STRING_ECHO_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            char_echo <= '0;
        end else if (state == WCHR) begin
            char_echo <= {~char_echo[TOG_BIT], char_q};
        end
    end
`endif

endmodule
